// File: rtl/cim_ark_sbox_initiator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cim_aes_pkg
//  Description : Shared types, constants and lane-slice helpers for the CIM
//                AddRoundKey/S-box initiator.
//                - FSM state encoding
//                - lane geometry (16 lanes, byte/DEMUX/RWL field offsets)
//                - IN complement pattern of bit-serial cycle c
//  Revision    : 1.0  initial release
// ============================================================================
package cim_aes_pkg;

    localparam int ARK_CYCLES = 8;
    localparam int LANES      = 16;
    localparam int DEMUX_W    = 3;
    localparam int RWL_W      = 6;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARK      = 3'd1,
        ST_ARK_TAIL = 3'd2,
        ST_LOOKUP   = 3'd3,
        ST_CAPTURE  = 3'd4
    } state_e;

    // Lane 0 sits in the most significant field of every bus.
    function automatic int byte_lsb(input int i);
        return 8 * (LANES - 1 - i);
    endfunction

    function automatic int demux_lsb(input int i);
        return DEMUX_W * (LANES - 1 - i);
    endfunction

    function automatic int rwl_lsb(input int i);
        return RWL_W * (LANES - 1 - i);
    endfunction

    // Complement pattern used when the inversion check is built in:
    // all lanes inverted on odd cycles, none on even cycles.
    function automatic logic [15:0] in_pattern(input logic [2:0] c);
        return ((c & 3'd1) != 3'd0) ? 16'hFFFF : 16'h0000;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cim_ark_sbox_initiator_if.sv
`default_nettype none
// ============================================================================
//  Module      : cim_ark_sbox_initiator_if
//  Description : Bundle between the AES round controller / CIM array and the
//                initiator.
//                master : initiator side (drives RDY/BSY/IN/addresses/DOUT/
//                         DVLD/ERR, receives START/STATE_IN/RIO)
//                slave  : controller + array side
//  Revision    : 1.0  initial release
// ============================================================================
interface cim_ark_sbox_initiator_if;
    import cim_aes_pkg::*;

    logic                       START;
    logic [127:0]               STATE_IN;
    logic [127:0]               RIO;
    logic                       RDY;
    logic                       BSY;
    logic [LANES-1:0]           IN;
    logic [LANES*DEMUX_W-1:0]   DEMUX_ADD;
    logic [LANES*RWL_W-1:0]     RWL_DEC_ADD;
    logic [127:0]               DOUT;
    logic                       DVLD;
    logic                       ERR;

    modport master (
        input  START, STATE_IN, RIO,
        output RDY, BSY, IN, DEMUX_ADD, RWL_DEC_ADD, DOUT, DVLD, ERR
    );

    modport slave (
        output START, STATE_IN, RIO,
        input  RDY, BSY, IN, DEMUX_ADD, RWL_DEC_ADD, DOUT, DVLD, ERR
    );
endinterface
`default_nettype wire

// File: rtl/cim_ark_sbox_initiator_transpose.sv
`default_nettype none
// ============================================================================
//  Module      : cim_plane_transpose
//  Description : Combinational transpose of the 16 captured bit-plane lanes
//                into the 128-bit round key K.
//                Lane k   (k=0..7) bit(7-j) -> K byte 2j   bit(7-k)
//                Lane k+8 (k=0..7) bit(7-j) -> K byte 2j+1 bit(7-k)
//  Ports       : i_planes  lane i at [127-8i -: 8]
//                o_key     K, byte 0 at [127:120]
//  Revision    : 1.0  initial release
// ============================================================================
module cim_plane_transpose (
    input  wire logic [127:0] i_planes,
    output logic      [127:0] o_key
);
    for (genvar j = 0; j < 8; j++) begin : g_byte_pair
        for (genvar k = 0; k < 8; k++) begin : g_bit
            assign o_key[127 - 16*j - k]     = i_planes[127 - 8*k - j];
            assign o_key[127 - 16*j - 8 - k] = i_planes[63 - 8*k - j];
        end
    end
endmodule
`default_nettype wire

// File: rtl/cim_ark_sbox_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : cim_ark_sbox_initiator
//  Description : Initiator of the CIM AddRoundKey/S-box exchange. Per START it
//                reads the round key K from the array as 8 bit-serial planes,
//                forms x = STATE_IN ^ K, drives x as S-box lookup addresses
//                and returns SubBytes(STATE_IN ^ K) on DOUT with a DVLD pulse.
//                Timeline after the accepting edge:
//                  t0..t7 ARK, t8 ARK_TAIL, t9 LOOKUP, t10 CAPTURE, DVLD t11.
//  Ports       : CLK, RST (synchronous, active high)
//                bus : cim_ark_sbox_initiator_if.master
//                      START, STATE_IN, RIO in; RDY, BSY, IN, DEMUX_ADD,
//                      RWL_DEC_ADD, DOUT, DVLD, ERR out
//  Config      : CIM_INV_CHECK_EN  alternate IN complement per cycle and flag
//                                  inconsistent captures on ERR
//  Revision    : 1.0  initial release
// ============================================================================
module cim_ark_sbox_initiator
    import cim_aes_pkg::*;
(
    input  wire logic                 CLK,
    input  wire logic                 RST,
    cim_ark_sbox_initiator_if.master  bus
);

    state_e         r_state;
    state_e         w_next;
    logic [2:0]     r_cnt;
    logic [127:0]   r_state_in;
    logic [127:0]   r_plane;
    logic [127:0]   r_dout;
    logic           r_dvld;

    logic           w_rdy;
    logic           w_bsy;
    logic           w_accept;
    logic           w_addr_en;
    logic [15:0]    w_in;
    logic [127:0]   w_cap_dc;
    logic [127:0]   w_plane_src;
    logic [127:0]   w_key;
    logic [127:0]   w_x;
    logic [47:0]    w_demux;
    logic [95:0]    w_rwl;

    // ------------------------------------------------------------------
    // FSM next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next    = r_state;
        w_rdy     = 1'b0;
        w_bsy     = 1'b0;
        w_addr_en = 1'b0;
        w_in      = '0;
        case (r_state)
            ST_IDLE: begin
                w_rdy = 1'b1;
                if (bus.START) w_next = ST_ARK;
            end
            ST_ARK: begin
                w_bsy = 1'b1;
`ifdef CIM_INV_CHECK_EN
                w_in  = in_pattern(r_cnt);
`endif
                if (r_cnt == 3'(ARK_CYCLES - 1)) w_next = ST_ARK_TAIL;
            end
            ST_ARK_TAIL: begin
                w_bsy     = 1'b1;
                w_addr_en = 1'b1;
                w_next    = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                w_bsy     = 1'b1;
                w_addr_en = 1'b1;
                w_next    = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                // A new START here chains straight into the next ARK phase.
                w_rdy  = 1'b1;
                w_next = bus.START ? ST_ARK : ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_accept = bus.START && w_rdy;

    // ------------------------------------------------------------------
    // Capture path. The response to ARK cycle c arrives one cycle later,
    // so captures happen in ARK cycles 1..7 (for c=0..6) and in ARK_TAIL
    // (for c=7).
    // ------------------------------------------------------------------
`ifdef CIM_INV_CHECK_EN
    logic [2:0]     w_cap_idx;
    logic [15:0]    w_cap_pat;
    logic           w_cap_en;
    logic           r_mis;
    logic           r_err;

    assign w_cap_idx = (r_state == ST_ARK_TAIL) ? 3'(ARK_CYCLES - 1) : (r_cnt - 3'd1);
    assign w_cap_en  = ((r_state == ST_ARK) && (r_cnt != 3'd0)) || (r_state == ST_ARK_TAIL);
    assign w_cap_pat = in_pattern(w_cap_idx);

    // Even-byte lanes carry the complement of IN[k+8], odd-byte lanes IN[k].
    always_comb begin
        w_cap_dc = '0;
        for (int k = 0; k < 8; k++) begin
            w_cap_dc[byte_lsb(k) +: 8]     = bus.RIO[byte_lsb(k) +: 8]     ^ {8{w_cap_pat[k+8]}};
            w_cap_dc[byte_lsb(k + 8) +: 8] = bus.RIO[byte_lsb(k + 8) +: 8] ^ {8{w_cap_pat[k]}};
        end
    end

    // Consecutive de-complemented captures must all agree; a chain of
    // pairwise equality is enough to prove all eight are identical.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_mis <= 1'b0;
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_mis <= 1'b0;
            r_err <= 1'b0;
        end else begin
            if (w_cap_en && (w_cap_idx != 3'd0) && (w_cap_dc != r_plane))
                r_mis <= 1'b1;
            if (r_state == ST_ARK_TAIL)
                r_err <= r_mis | (w_cap_dc != r_plane);
        end
    end

    assign bus.ERR = r_err;
`else
    assign w_cap_dc = bus.RIO;
    assign bus.ERR  = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Key and lookup addresses. In ARK_TAIL the final plane is still on
    // RIO (it is stored at the end of that cycle), so the addresses are
    // formed from the live capture there and from the stored plane after.
    // ------------------------------------------------------------------
    assign w_plane_src = (r_state == ST_ARK_TAIL) ? w_cap_dc : r_plane;

    cim_plane_transpose u_transpose (
        .i_planes (w_plane_src),
        .o_key    (w_key)
    );

    assign w_x = r_state_in ^ w_key;

    always_comb begin
        w_demux = '0;
        w_rwl   = '0;
        if (w_addr_en) begin
            for (int i = 0; i < LANES; i++) begin
                w_demux[demux_lsb(i) +: DEMUX_W] = {1'b0, w_x[byte_lsb(i) + 6 +: 2]};
                w_rwl[rwl_lsb(i) +: RWL_W]       = w_x[byte_lsb(i) +: 6];
            end
        end
    end

    // ------------------------------------------------------------------
    // State register and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 3'd0;
            r_state_in <= '0;
            r_plane    <= '0;
            r_dout     <= '0;
            r_dvld     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_dvld  <= (r_state == ST_CAPTURE);
            if (w_accept) begin
                r_cnt      <= 3'd0;
                r_state_in <= bus.STATE_IN;
            end else if (r_state == ST_ARK) begin
                r_cnt <= r_cnt + 3'd1;
            end
            if (r_state == ST_CAPTURE)
                r_dout <= bus.RIO;
`ifdef CIM_INV_CHECK_EN
            // Last write wins, so the c=7 capture is the one kept as K.
            if (w_cap_en)
                r_plane <= w_cap_dc;
`else
            if (r_state == ST_ARK_TAIL)
                r_plane <= w_cap_dc;
`endif
        end
    end

    assign bus.RDY         = w_rdy;
    assign bus.BSY         = w_bsy;
    assign bus.IN          = w_in;
    assign bus.DEMUX_ADD   = w_demux;
    assign bus.RWL_DEC_ADD = w_rwl;
    assign bus.DOUT        = r_dout;
    assign bus.DVLD        = r_dvld;

endmodule
`default_nettype wire
